// File: rtl/mem_port_arbiter_pkg.sv
// ------------------------------------------------------------------
// mem_arb_pkg : shared encodings for mem_port_arbiter.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;
  localparam int WCNT_W   = 3;
  localparam int STARVE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ------------------------------------------------------------------
// mem_port_arbiter_if : requester and memory bus bundle.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    input  if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
// ------------------------------------------------------------------
// arb_starve_ctr : saturating fetch-starvation counter.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic inc,
  input  wire logic clr,
  output logic      at_max
);
  logic [STARVE_W-1:0] cnt;

  assign at_max = (cnt == STARVE_W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------
// mem_port_arbiter : fetch/data arbiter for a single-port memory. Rev 1.0
// MEM_ARB_STATS_EN adds saturating grant and stall statistics outputs.
// ------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]        stat_if_grants,
  output logic [31:0]        stat_d_grants,
  output logic [31:0]        stat_stall_cycles
`endif
);
  state_t              state;
  logic                owner;
  logic                op;
  logic                discard;
  logic [WCNT_W-1:0]   wcnt;
  logic [DATA_W-1:0]   rbuf;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic [ADDR_W-1:0]   grant_addr;
  logic                d_req;
  logic                at_max;
  logic                grant_if;
  logic                grant_d;
  logic                grant_wr;
  logic                in_done;
  logic                if_done_ok;
  logic                d_done_ok;
  logic                d_load_ok;

  assign d_req      = bus.d_rd | bus.d_wr;
  assign grant_if   = (state == IDLE) & bus.if_req & ~bus.if_flush & (at_max | ~d_req);
  assign grant_d    = (state == IDLE) & d_req & ~grant_if;
  assign grant_wr   = grant_d & bus.d_wr;
  assign grant_addr = grant_d ? bus.d_addr : bus.if_addr;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (grant_d & bus.if_req),
    .clr    (grant_if),
    .at_max (at_max)
  );

  // A flush landing in DONE itself must still suppress the pulse, so the
  // completion outputs are decoded combinationally from the DONE state.
  assign in_done    = (state == DONE);
  assign if_done_ok = in_done & (owner == OWN_IF) & ~discard & ~bus.if_flush;
  assign d_done_ok  = in_done & (owner == OWN_D);
  assign d_load_ok  = d_done_ok & (op == OP_RD);

  assign bus.if_valid = if_done_ok;
  assign bus.d_valid  = d_done_ok;
  assign bus.if_rdata = if_done_ok ? rbuf : if_rdata_q;
  assign bus.d_rdata  = d_load_ok  ? rbuf : d_rdata_q;
  assign bus.if_stall = rst_n & bus.if_req & ~if_done_ok;
  assign bus.d_stall  = rst_n & d_req & ~d_done_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      op            <= OP_RD;
      discard       <= 1'b0;
      wcnt          <= '0;
      rbuf          <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
    end else begin
      bus.mem_rd <= (grant_if | grant_d) & ~grant_wr;
      bus.mem_wr <= grant_wr;

      if (state == DONE) begin
        discard <= 1'b0;
      end else if ((state != IDLE) && (owner == OWN_IF) && bus.if_flush) begin
        discard <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_if | grant_d) begin
            owner        <= grant_d ? OWN_D : OWN_IF;
            op           <= grant_wr ? OP_WR : OP_RD;
            bus.mem_addr <= grant_addr;
            if (grant_wr) begin
              bus.mem_wdata <= bus.d_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (op == OP_WR) begin
            state <= DONE;
          end else begin
            wcnt  <= WCNT_W'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            rbuf  <= bus.mem_rdata;
            state <= DONE;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        DONE: begin
          if (if_done_ok) begin
            if_rdata_q <= rbuf;
          end
          if (d_load_ok) begin
            d_rdata_q <= rbuf;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants    <= '0;
      stat_d_grants     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (grant_if && (stat_if_grants != '1)) begin
        stat_if_grants <= stat_if_grants + 1'b1;
      end
      if (grant_d && (stat_d_grants != '1)) begin
        stat_d_grants <= stat_d_grants + 1'b1;
      end
      if ((bus.if_stall | bus.d_stall) && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
      end
    end
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench.    Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] sa_if, sa_d, sa_st, sb_if, sb_d, sb_st;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_grants(sa_if), .stat_d_grants(sa_d), .stat_stall_cycles(sa_st)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_grants(sb_if), .stat_d_grants(sb_d), .stat_stall_cycles(sb_st)
`endif
  );

  logic [31:0] t3_addr [6] = '{32'h200, 32'h200, 32'h80, 32'h200, 32'h200, 32'h80};
  logic [3:0]  t3_cnt  [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.if_flush = 0; bus_a.d_rd = 0;
    bus_a.d_wr = 0; bus_a.d_addr = 0; bus_a.d_wdata = 0; bus_a.mem_rdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.if_flush = 0; bus_b.d_rd = 0;
    bus_b.d_wr = 0; bus_b.d_addr = 0; bus_b.d_wdata = 0; bus_b.mem_rdata = 0;
    rst_n = 1'b0;
    cyc(2);
    chkb("rst_mem_rd", bus_a.mem_rd, 1'b0);
    chkb("rst_mem_wr", bus_a.mem_wr, 1'b0);
    chkb("rst_if_valid", bus_a.if_valid, 1'b0);
    chkb("rst_d_valid", bus_a.d_valid, 1'b0);
    chk("rst_mem_addr", bus_a.mem_addr, 32'h0);
    chk("rst_if_rdata", bus_a.if_rdata, 32'h0);
    chk("rst_starve", 32'(dut_a.u_starve.cnt), 32'd0);
    chk("rst_state", 32'(dut_a.state), 32'(IDLE));
    rst_n = 1'b1;
    cyc();

    // Fetch only, MEM_LAT=1.
    bus_a.if_req = 1; bus_a.if_addr = 32'h40; bus_a.mem_rdata = 32'h8C010004;
    #1;
    chkb("t1_c0_stall", bus_a.if_stall, 1'b1);
    chkb("t1_c0_rd", bus_a.mem_rd, 1'b0);
    cyc();
    chkb("t1_c1_rd", bus_a.mem_rd, 1'b1);
    chk("t1_c1_addr", bus_a.mem_addr, 32'h40);
    chkb("t1_c1_stall", bus_a.if_stall, 1'b1);
    cyc();
    chkb("t1_c2_rd", bus_a.mem_rd, 1'b0);
    chkb("t1_c2_valid", bus_a.if_valid, 1'b0);
    chkb("t1_c2_stall", bus_a.if_stall, 1'b1);
    cyc();
    chkb("t1_c3_valid", bus_a.if_valid, 1'b1);
    chk("t1_c3_rdata", bus_a.if_rdata, 32'h8C010004);
    chkb("t1_c3_stall", bus_a.if_stall, 1'b0);
    bus_a.if_req = 0;
    cyc();
    chkb("t1_c4_valid", bus_a.if_valid, 1'b0);
    chk("t1_c4_rdata", bus_a.if_rdata, 32'h8C010004);

    // Simultaneous fetch and store: store first.
    bus_a.if_req = 1; bus_a.if_addr = 32'h44; bus_a.d_wr = 1; bus_a.d_addr = 32'h100;
    bus_a.d_wdata = 32'hDEADBEEF; bus_a.mem_rdata = 32'h11112222;
    #1;
    chkb("t2_c0_dstall", bus_a.d_stall, 1'b1);
    cyc();
    chkb("t2_c1_wr", bus_a.mem_wr, 1'b1);
    chkb("t2_c1_rd", bus_a.mem_rd, 1'b0);
    chk("t2_c1_addr", bus_a.mem_addr, 32'h100);
    chk("t2_c1_wdata", bus_a.mem_wdata, 32'hDEADBEEF);
    cyc();
    chkb("t2_c2_dvalid", bus_a.d_valid, 1'b1);
    chkb("t2_c2_wr", bus_a.mem_wr, 1'b0);
    chkb("t2_c2_dstall", bus_a.d_stall, 1'b0);
    bus_a.d_wr = 0;
    cyc();
    chkb("t2_c3_rd", bus_a.mem_rd, 1'b0);
    chk("t2_c3_starve", 32'(dut_a.u_starve.cnt), 32'd1);
    cyc();
    chkb("t2_c4_rd", bus_a.mem_rd, 1'b1);
    chk("t2_c4_addr", bus_a.mem_addr, 32'h44);
    chk("t2_c4_starve", 32'(dut_a.u_starve.cnt), 32'd0);
    cyc(2);
    chkb("t2_c6_valid", bus_a.if_valid, 1'b1);
    chk("t2_c6_rdata", bus_a.if_rdata, 32'h11112222);
    bus_a.if_req = 0;
    cyc();

    // Continuous fetch and load with STARVE_MAX=2: D, D, IF, D, D, IF.
    bus_a.if_req = 1; bus_a.if_addr = 32'h80; bus_a.d_rd = 1; bus_a.d_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      int w;
      w = 0;
      do begin
        cyc();
        w++;
      end while (!bus_a.mem_rd && w < 8);
      chkb($sformatf("t3_g%0d_rd", g), bus_a.mem_rd, 1'b1);
      chk($sformatf("t3_g%0d_addr", g), bus_a.mem_addr, t3_addr[g]);
      chk($sformatf("t3_g%0d_starve", g), 32'(dut_a.u_starve.cnt), 32'(t3_cnt[g]));
    end
    bus_a.if_req = 0; bus_a.d_rd = 0;
    cyc(3);

    // Flush during WAIT of a fetch.
    bus_a.mem_rdata = 32'h33334444; bus_a.if_req = 1; bus_a.if_addr = 32'h90;
    cyc();
    chkb("t4_c1_rd", bus_a.mem_rd, 1'b1);
    chk("t4_c1_addr", bus_a.mem_addr, 32'h90);
    cyc();
    bus_a.if_flush = 1;
    #1;
    chkb("t4_c2_valid", bus_a.if_valid, 1'b0);
    cyc();
    bus_a.if_flush = 0;
    #1;
    chkb("t4_c3_valid", bus_a.if_valid, 1'b0);
    chk("t4_c3_rdata", bus_a.if_rdata, 32'h11112222);
    bus_a.if_addr = 32'h94;
    cyc();
    chkb("t4_c4_rd", bus_a.mem_rd, 1'b0);
    cyc();
    chkb("t4_c5_rd", bus_a.mem_rd, 1'b1);
    chk("t4_c5_addr", bus_a.mem_addr, 32'h94);
    cyc(2);
    chkb("t4_c7_valid", bus_a.if_valid, 1'b1);
    chk("t4_c7_rdata", bus_a.if_rdata, 32'h33334444);
    bus_a.if_req = 0;
    cyc();

    // Asynchronous reset during WAIT of a load.
    bus_a.d_rd = 1; bus_a.d_addr = 32'h300; bus_a.mem_rdata = 32'h55556666;
    cyc();
    chkb("t5_c1_rd", bus_a.mem_rd, 1'b1);
    cyc();
    rst_n = 1'b0;
    #1;
    chkb("t5_rst_rd", bus_a.mem_rd, 1'b0);
    chkb("t5_rst_dstall", bus_a.d_stall, 1'b0);
    chkb("t5_rst_dvalid", bus_a.d_valid, 1'b0);
    chk("t5_rst_drdata", bus_a.d_rdata, 32'h0);
    chk("t5_rst_ifrdata", bus_a.if_rdata, 32'h0);
    cyc();
    chkb("t5_rst_dvalid2", bus_a.d_valid, 1'b0);
    chk("t5_rst_state", 32'(dut_a.state), 32'(IDLE));
    rst_n = 1'b1;
    cyc();
    chkb("t5_n1_rd", bus_a.mem_rd, 1'b1);
    chk("t5_n1_addr", bus_a.mem_addr, 32'h300);
    cyc();
    chkb("t5_n2_dvalid", bus_a.d_valid, 1'b0);
    cyc();
    chkb("t5_n3_dvalid", bus_a.d_valid, 1'b1);
    chk("t5_n3_drdata", bus_a.d_rdata, 32'h55556666);
    bus_a.d_rd = 0;
    cyc();

    // MEM_LAT=3: load latency, then simultaneous rd+wr treated as a store.
    bus_b.d_rd = 1; bus_b.d_addr = 32'h24; bus_b.mem_rdata = 32'hA5A5A5A5;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) chkb("t6_ld_rd", bus_b.mem_rd, 1'b1);
      chkb($sformatf("t6_ld_c%0d_dvalid", c), bus_b.d_valid, c == 5);
    end
    chk("t6_ld_drdata", bus_b.d_rdata, 32'hA5A5A5A5);
    bus_b.d_rd = 0;
    cyc();
    bus_b.d_rd = 1; bus_b.d_wr = 1; bus_b.d_addr = 32'h20;
    bus_b.d_wdata = 32'hCAFEF00D; bus_b.mem_rdata = 32'h0BADF00D;
    cyc();
    chkb("t6_c1_wr", bus_b.mem_wr, 1'b1);
    chkb("t6_c1_rd", bus_b.mem_rd, 1'b0);
    chk("t6_c1_addr", bus_b.mem_addr, 32'h20);
    chk("t6_c1_wdata", bus_b.mem_wdata, 32'hCAFEF00D);
    cyc();
    chkb("t6_c2_dvalid", bus_b.d_valid, 1'b1);
    chk("t6_c2_drdata", bus_b.d_rdata, 32'hA5A5A5A5);
    bus_b.d_rd = 0; bus_b.d_wr = 0;
    cyc();
    chkb("t6_c3_dvalid", bus_b.d_valid, 1'b0);
    chk("t6_c3_drdata", bus_b.d_rdata, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port shared instruction/data memory between the pipeline's fetch stage and its MEM-stage load/store unit.
- Replaces ad-hoc address muxing with a sequenced, one-outstanding-transaction controller.
- Returns per-requester valid pulses and stall signals, which feed the pipeline's hazard logic.
- Enforces data-over-fetch priority with a bounded fetch-starvation guarantee.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from the memory command cycle to valid mem_rdata. Legal values 1..7.
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced. Legal values 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  branch/jump flush; discards the in-flight fetch response.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  fetch stage must hold.
- d_rd  in  1  load request.
- d_wr  in  1  store request.
- d_addr  in  ADDR_W  load/store address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle load/store completion pulse.
- d_stall  out  1  MEM stage must hold.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE, starvation counter 0.
  - All outputs 0, including mem_rd/mem_wr, which drop immediately.
  - Any in-flight transaction is abandoned; no valid pulse follows.
- Requester rules:
  - A requester holds its request and operands stable until it sees its valid pulse.
  - Operands are latched at grant; later changes are ignored.
- States:
  - IDLE: on a grant, latch owner, address, wdata and op, then go to ACCESS. With no request, stay in IDLE.
  - ACCESS (exactly 1 cycle): drive mem_addr and one of mem_rd/mem_wr, plus mem_wdata for stores. Stores go to DONE; reads go to WAIT with wait counter = MEM_LAT-1.
  - WAIT: decrement each cycle. At 0, register mem_rdata into the owner's rdata register and go to DONE. When MEM_LAT=1, WAIT lasts 1 cycle.
  - DONE (1 cycle): pulse the owner's valid (subject to flush suppression), then return to IDLE.
- Latency, with request seen in IDLE at cycle 0:
  - Store: d_valid in cycle 2.
  - Read: valid in cycle 2+MEM_LAT. With MEM_LAT=1, valid in cycle 3.
  - Back-to-back throughput: one transaction per 3+MEM_LAT cycles for reads, 3 for stores.
- Grant selection in IDLE:
  - Data request present (d_rd|d_wr): data wins.
  - Exception: fetch wins when if_req is high and starve_cnt==STARVE_MAX.
  - starve_cnt: increments (saturating) on a data grant while if_req is high; clears on a fetch grant.
  - Fetch-only request: fetch wins unless if_flush is high that cycle, in which case there is no grant.
- d_rd and d_wr both high: treated as a store; the read is ignored.
- Flush during a fetch transaction:
  - If if_flush is high in any cycle from ACCESS through DONE of a fetch, set a sticky discard flag.
  - The memory access completes, if_valid is suppressed and if_rdata is not updated.
  - The discard flag clears on return to IDLE.
- Request deasserted mid-transaction: the transaction completes and valid still pulses. The requester ignores it.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - d_stall = (d_rd|d_wr) & ~d_valid.
- Idle bus: mem_rd/mem_wr are 0 outside ACCESS, and mem_addr/mem_wdata hold their last values.
- rdata registers hold their value until the next completion for the same owner.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_if_grants, stat_d_grants and stat_stall_cycles, each 32 bits.
  - Each counter saturates at all-ones and clears on reset.
  - stat_stall_cycles counts cycles with if_stall|d_stall.
  - A discarded fetch still counts as a grant.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum IDLE/ACCESS/WAIT/DONE.
  - owner encoding OWN_IF=0, OWN_D=1.
  - op encoding OP_RD/OP_WR.
  - width constants for the wait counter (3 bits) and the starve counter (4 bits).
- Sub-module arb_starve_ctr: saturating starvation counter with inc/clr inputs and an at_max output.

Test Plan:
1. Fetch only, MEM_LAT=1, if_addr=0x40, memory returns 0x8C010004 → mem_rd high in cycle 1; if_valid in cycle 3 with if_rdata=0x8C010004; if_stall high in cycles 0–2.
2. Simultaneous if_req and d_wr (addr 0x100, data 0xDEADBEEF) → store granted first; mem_wr in cycle 1; d_valid in cycle 2; fetch granted in the next IDLE.
3. STARVE_MAX=2, continuous d_rd and if_req → grant order D, D, IF, D, D, IF; starve_cnt returns to 0 after each IF grant.
4. if_flush asserted in the WAIT cycle of a fetch → mem_rd still issued; no if_valid pulse; if_rdata unchanged; next fetch proceeds normally.
5. reset driven low during WAIT of a load → mem_rd, d_valid and stalls go to 0 immediately; after release, state is IDLE and a new load completes with normal latency.
6. MEM_LAT=3, with d_rd and d_wr both high on addr 0x20 → a write is issued (mem_wr=1, mem_rd=0); d_valid in cycle 2; mem_rdata is never sampled.
